hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 146 ++++++++++++++
 tb/tb_hazard_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Hazard detection and operand forwarding for the ID stage, plus divide tracking for HI/LO.
// Optional build macro: HAZARD_BRANCH_ID_EN. When it is defined, branches that resolve in ID
// also stall on an EX-stage producer and on a stage-1 load.
module hazard_unit #(
    parameter int unsigned NFWD       = 2,
    parameter int unsigned DIV_CYCLES = 33,
    localparam int unsigned FW        = $clog2(NFWD + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              id_use_hilo,
    input  logic [NFWD-1:0]   fwd_we,
    input  logic [5*NFWD-1:0] fwd_reg,
    input  logic [NFWD-1:0]   fwd_is_load,
    input  logic              md_start,
    input  logic              md_is_div,
    input  logic              exc_flush,
    output logic [FW-1:0]     fwda,
    output logic [FW-1:0]     fwdb,
    output logic              stall_if,
    output logic              stall_id,
    output logic              bubble_ex,
    output logic              md_busy,
    output logic              md_done,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [NFWD-1:0] match_rs, match_rt;
    logic        load_a, load_b;
    logic        load_use_hz, hilo_hz, branch_hz, stall;

    // Per-stage operand match against the ID source registers; r0 never forwards.
    always_comb begin
        match_rs = '0;
        match_rt = '0;
        for (int k = 0; k < NFWD; k++) begin
            match_rs[k] = fwd_we[k] && (fwd_reg[5*k +: 5] != 5'd0) &&
                          (fwd_reg[5*k +: 5] == id_rs) && id_use_rs;
            match_rt[k] = fwd_we[k] && (fwd_reg[5*k +: 5] != 5'd0) &&
                          (fwd_reg[5*k +: 5] == id_rt) && id_use_rt;
        end
    end

    // Priority select: scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwda   = '0;
        fwdb   = '0;
        load_a = 1'b0;
        load_b = 1'b0;
        for (int k = NFWD - 1; k >= 0; k--) begin
            if (match_rs[k]) begin
                fwda   = FW'(k + 1);
                load_a = fwd_is_load[k];
            end
            if (match_rt[k]) begin
                fwdb   = FW'(k + 1);
                load_b = fwd_is_load[k];
            end
        end
    end

`ifdef HAZARD_BRANCH_ID_EN
    // ID-resolved branches cannot use an EX result, nor a load still in stage 1.
    always_comb begin
        branch_hz = 1'b0;
        for (int k = 0; k < NFWD; k++) begin
            if (k == 0 && (match_rs[k] || match_rt[k])) begin
                branch_hz = 1'b1;
            end else if (k == 1 && fwd_is_load[k] && (match_rs[k] || match_rt[k])) begin
                branch_hz = 1'b1;
            end
        end
        branch_hz = branch_hz && id_is_branch && id_valid;
    end
`else
    logic unused_branch;
    assign unused_branch = id_is_branch;
    assign branch_hz     = 1'b0;
`endif

    // Stall sources; a flush or an active reset forces all stall outputs low.
    always_comb begin
        load_use_hz = id_valid && (load_a || load_b);
        hilo_hz     = (state_q == StBusy) && id_valid && id_use_hilo;
        stall       = resetn && !exc_flush && (load_use_hz || hilo_hz || branch_hz);
        stall_if    = stall;
        stall_id    = stall;
        bubble_ex   = stall;
        md_busy     = (state_q == StBusy);
    end

    // Divide tracker: the counter hits 0 in the final busy cycle, which carries md_done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_done = 1'b0;
        if (exc_flush) begin
            state_d = StIdle;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (md_start && md_is_div) begin
                        state_d = StBusy;
                        cnt_d   = 8'(DIV_CYCLES - 1);
                    end
                end
                StBusy: begin
                    if (cnt_q == 8'd0) begin
                        md_done = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State, counter and stall statistics registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            cnt_q        <= 8'd0;
            stall_cycles <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_id) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit with default parameters (NFWD=2, DIV_CYCLES=33).
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid, id_use_rs, id_use_rt, id_is_branch, id_use_hilo;
    logic [4:0]  id_rs, id_rt;
    logic [1:0]  fwd_we, fwd_is_load;
    logic [9:0]  fwd_reg;
    logic        md_start, md_is_div, exc_flush;
    logic [1:0]  fwda, fwdb;
    logic        stall_if, stall_id, bubble_ex, md_busy, md_done;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;

`ifdef HAZARD_BRANCH_ID_EN
    localparam logic BR_EN = 1'b1;
`else
    localparam logic BR_EN = 1'b0;
`endif

    hazard_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .id_use_hilo  (id_use_hilo),
        .fwd_we       (fwd_we),
        .fwd_reg      (fwd_reg),
        .fwd_is_load  (fwd_is_load),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .exc_flush    (exc_flush),
        .fwda         (fwda),
        .fwdb         (fwdb),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_stall(input string name, input logic exp);
        check({name, "_stall_if"}, {31'd0, stall_if}, {31'd0, exp});
        check({name, "_stall_id"}, {31'd0, stall_id}, {31'd0, exp});
        check({name, "_bubble_ex"}, {31'd0, bubble_ex}, {31'd0, exp});
    endtask

    typedef struct {
        string      name;
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic       br;
        logic       hilo;
        logic [1:0] we;
        logic [1:0] ld;
        logic [9:0] regs;
        logic [1:0] efa;
        logic [1:0] efb;
        logic       estall;
    } vec_t;

    vec_t vecs[11];

    task automatic clear_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_is_branch = 0; id_use_hilo = 0; fwd_we = 0; fwd_reg = 0; fwd_is_load = 0;
        md_start = 0; md_is_div = 0; exc_flush = 0;
    endtask

    task automatic apply(input vec_t v);
        id_valid = v.valid; id_rs = v.rs; id_rt = v.rt; id_use_rs = v.use_rs;
        id_use_rt = v.use_rt; id_is_branch = v.br; id_use_hilo = v.hilo;
        fwd_we = v.we; fwd_is_load = v.ld; fwd_reg = v.regs;
    endtask

    initial begin
        bit seen_done;
        // name, valid, rs, rt, use_rs, use_rt, br, hilo, we, ld, {reg1,reg0}, fwda, fwdb, stall
        vecs[0]  = '{"fwd_young", 1, 5, 5, 1, 0, 0, 0, 2'b11, 2'b00, {5'd5, 5'd5}, 1, 0, 0};
        vecs[1]  = '{"ld_use_s1", 1, 0, 7, 1, 1, 0, 0, 2'b11, 2'b10, {5'd7, 5'd0}, 0, 2, 1};
        vecs[2]  = '{"ld_invalid", 0, 0, 7, 1, 1, 0, 0, 2'b11, 2'b10, {5'd7, 5'd0}, 0, 2, 0};
        vecs[3]  = '{"fwd_old", 1, 9, 0, 1, 0, 0, 0, 2'b10, 2'b00, {5'd9, 5'd9}, 2, 0, 0};
        vecs[4]  = '{"ld_use_s0", 1, 4, 0, 1, 0, 0, 0, 2'b01, 2'b01, {5'd0, 5'd4}, 1, 0, 1};
        vecs[5]  = '{"young_hides_ld", 1, 6, 0, 1, 0, 0, 0, 2'b11, 2'b10, {5'd6, 5'd6}, 1, 0, 0};
        vecs[6]  = '{"no_use", 1, 6, 6, 0, 0, 0, 0, 2'b11, 2'b11, {5'd6, 5'd6}, 0, 0, 0};
        vecs[7]  = '{"split", 1, 3, 8, 1, 1, 0, 0, 2'b11, 2'b00, {5'd8, 5'd3}, 1, 2, 0};
        vecs[8]  = '{"branch_ex", 1, 3, 0, 1, 0, 1, 0, 2'b01, 2'b00, {5'd0, 5'd3}, 1, 0, BR_EN};
        vecs[9]  = '{"hilo_idle", 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 10'd0, 0, 0, 0};
        vecs[10] = '{"rt_ld_s0", 1, 1, 2, 1, 1, 0, 0, 2'b11, 2'b01, {5'd1, 5'd2}, 2, 1, 1};

        // Reset: stall outputs held low even with a load-use pattern on the inputs.
        clear_inputs();
        resetn = 0;
        apply(vecs[1]);
        #1;
        check_stall("reset", 1'b0);
        check("reset_busy", {31'd0, md_busy}, 32'd0);
        check("reset_done", {31'd0, md_done}, 32'd0);
        check("reset_sc", stall_cycles, 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1;
        clear_inputs();

        // Combinational forwarding / load-use vectors.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            check({vecs[i].name, "_fwda"}, {30'd0, fwda}, {30'd0, vecs[i].efa});
            check({vecs[i].name, "_fwdb"}, {30'd0, fwdb}, {30'd0, vecs[i].efb});
            check_stall(vecs[i].name, vecs[i].estall);
            @(posedge clk);
            if (vecs[i].estall) exp_sc++;
            #1;
            check({vecs[i].name, "_sc"}, stall_cycles, exp_sc);
        end

        // Full divide with mfhi waiting in ID; a second divide start mid-flight is ignored.
        @(negedge clk);
        clear_inputs();
        id_valid = 1; id_use_hilo = 1; md_start = 1; md_is_div = 1;
        #1;
        check_stall("div_c0", 1'b0);
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= 33; c++) begin
            md_start = (c == 5);
            #1;
            check($sformatf("div_busy_c%0d", c), {31'd0, md_busy}, 32'd1);
            check($sformatf("div_stall_c%0d", c), {31'd0, stall_id}, 32'd1);
            check($sformatf("div_done_c%0d", c), {31'd0, md_done}, {31'd0, c == 33});
            @(posedge clk);
            exp_sc++;
            @(negedge clk);
        end
        md_start = 0;
        #1;
        check("div_end_busy", {31'd0, md_busy}, 32'd0);
        check("div_end_done", {31'd0, md_done}, 32'd0);
        check_stall("div_end", 1'b0);
        check("div_sc", stall_cycles, exp_sc);

        // Multiply does not occupy the tracker.
        md_start = 1; md_is_div = 0;
        @(posedge clk);
        @(negedge clk);
        md_start = 0;
        #1;
        check("mult_busy", {31'd0, md_busy}, 32'd0);

        // Flush while the counter holds 10 (cycle 23 of the divide).
        md_start = 1; md_is_div = 1;
        @(posedge clk);
        @(negedge clk);
        md_start = 0;
        for (int c = 1; c < 23; c++) begin
            @(posedge clk);
            exp_sc++;
            @(negedge clk);
        end
        exc_flush = 1;
        #1;
        check_stall("flush", 1'b0);
        check("flush_done", {31'd0, md_done}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        exc_flush = 0;
        #1;
        check("flush_idle", {31'd0, md_busy}, 32'd0);
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (md_done) seen_done = 1;
        end
        check("flush_no_done", {31'd0, seen_done}, 32'd0);
        check("flush_sc", stall_cycles, exp_sc);

        // Asynchronous reset mid-divide, then a divide accepted on the first edge after release.
        @(negedge clk);
        id_use_hilo = 0;
        md_start = 1; md_is_div = 1;
        @(posedge clk);
        @(negedge clk);
        md_start = 0;
        repeat (3) @(posedge clk);
        #2;
        resetn = 0;
        #1;
        check("arst_busy", {31'd0, md_busy}, 32'd0);
        check("arst_sc", stall_cycles, 32'd0);
        check("arst_done", {31'd0, md_done}, 32'd0);
        @(negedge clk);
        md_start = 1; md_is_div = 1;
        resetn = 1;
        @(posedge clk);
        @(negedge clk);
        md_start = 0;
        #1;
        check("post_rst_div", {31'd0, md_busy}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
